// File: rtl/sparse_mac_operand_streamer.sv
// Sparse MAC operand streamer: expands compressed transfer blocks of a
// compression window, keeps only the positions present in both the input
// bitmask and the mutual mask, and repacks the kept clusters into dense
// TRANSFER_SIZE-wide beats for the MAC. A short residual is carried across
// windows and flushed (with out_last) when a window marked last completes.
//
// Ports:
//   clock, resetn                      clock / async active-low reset
//   win_valid/win_ready                window descriptor handshake
//   win_bitmask, win_mutual, win_last  window descriptor payload
//   in_valid/in_ready/in_data          compressed transfer blocks (lane 0 in LSBs)
//   out_valid/out_ready/out_data       dense operand beats
//   out_count, out_last                valid lanes in beat / final beat of a group
module sparse_mac_operand_streamer #(
  parameter int unsigned TRANSFER_SIZE           = 2,
  parameter int unsigned CLUSTER_BITWIDTH        = 16,
  parameter int unsigned COMPRESSION_WINDOW_SIZE = 8
) (
  input  logic                                        clock,
  input  logic                                        resetn,
  input  logic                                        win_valid,
  output logic                                        win_ready,
  input  logic [COMPRESSION_WINDOW_SIZE-1:0]          win_bitmask,
  input  logic [COMPRESSION_WINDOW_SIZE-1:0]          win_mutual,
  input  logic                                        win_last,
  input  logic                                        in_valid,
  output logic                                        in_ready,
  input  logic [CLUSTER_BITWIDTH*TRANSFER_SIZE-1:0]   in_data,
  output logic                                        out_valid,
  input  logic                                        out_ready,
  output logic [CLUSTER_BITWIDTH*TRANSFER_SIZE-1:0]   out_data,
  output logic [$clog2(TRANSFER_SIZE+1)-1:0]          out_count,
  output logic                                        out_last
);

  localparam int unsigned TS     = TRANSFER_SIZE;
  localparam int unsigned CB     = CLUSTER_BITWIDTH;
  localparam int unsigned CW     = COMPRESSION_WINDOW_SIZE;
  localparam int unsigned CNT_W  = $clog2(TS + 1);
  localparam int unsigned PC_W   = $clog2(CW + 1);
  localparam int unsigned BASE_W = $clog2(CW + TS + 1);
  localparam int unsigned IDX_W  = $clog2(2 * TS);

  typedef enum logic [1:0] {S_IDLE, S_STREAM, S_FLUSH} state_t;

  state_t                     r_state;
  logic                       r_armed;
  logic [CW-1:0]              r_mask;
  logic [CW-1:0]              r_mut;
  logic                       r_last;
  logic [PC_W-1:0]            r_pop;
  logic [BASE_W-1:0]          r_base;
  logic [TS-1:0][CB-1:0]      r_carry;
  logic [CNT_W-1:0]           r_res;
  logic                       r_out_valid;
  logic [TS-1:0][CB-1:0]      r_out_data;
  logic [CNT_W-1:0]           r_out_count;
  logic                       r_out_last;

  logic [PC_W-1:0]            w_pop;
  logic [TS-1:0]              w_keep;
  logic [2*TS-1:0][CB-1:0]    w_comb;
  logic [IDX_W-1:0]           w_total;
  logic                       w_full;
  logic                       w_out_free;
  logic                       w_in_fire;
  logic                       w_last_blk;

  assign win_ready  = r_armed && (r_state == S_IDLE);
  assign w_out_free = !r_out_valid || out_ready;
  assign in_ready   = (r_state == S_STREAM) && w_out_free;
  assign w_in_fire  = in_valid && in_ready;
  assign w_full     = (w_total >= IDX_W'(TS));
  assign w_last_blk = (r_base + BASE_W'(TS)) >= BASE_W'(r_pop);

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_count = r_out_count;
  assign out_last  = r_out_last;

  // Number of present positions in the offered window.
  always_comb begin
    w_pop = '0;
    for (int p = 0; p < CW; p++) w_pop = w_pop + PC_W'(win_bitmask[p]);
  end

  // Lane j of the current block is the (base+j)-th set bitmask position;
  // it is kept only if that position is also in the mutual mask.
  always_comb begin : keep_lanes
    logic [PC_W-1:0] v_rank;
    w_keep = '0;
    v_rank = '0;
    for (int p = 0; p < CW; p++) begin
      if (r_mask[p]) begin
        for (int j = 0; j < TS; j++) begin
          if (r_mut[p] && (BASE_W'(v_rank) == r_base + BASE_W'(j))) w_keep[j] = 1'b1;
        end
        v_rank = v_rank + PC_W'(1);
      end
    end
  end

  // Residual followed by kept lanes, oldest in slot 0; unused slots stay zero.
  always_comb begin : pack_lanes
    w_comb  = '0;
    w_total = IDX_W'(r_res);
    for (int j = 0; j < TS; j++) begin
      if (CNT_W'(j) < r_res) w_comb[j] = r_carry[j];
    end
    for (int j = 0; j < TS; j++) begin
      if (w_keep[j]) begin
        w_comb[w_total] = in_data[j*CB +: CB];
        w_total         = w_total + IDX_W'(1);
      end
    end
  end

  // Control FSM, carry buffer and output beat register.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state     <= S_IDLE;
      r_armed     <= 1'b0;
      r_mask      <= '0;
      r_mut       <= '0;
      r_last      <= 1'b0;
      r_pop       <= '0;
      r_base      <= '0;
      r_carry     <= '0;
      r_res       <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_count <= '0;
      r_out_last  <= 1'b0;
    end else begin
      r_armed <= 1'b1;
      if (r_out_valid && out_ready) r_out_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (win_ready && win_valid) begin
            r_mask <= win_bitmask;
            r_mut  <= win_mutual;
            r_last <= win_last;
            r_pop  <= w_pop;
            r_base <= '0;
            if (w_pop != '0)   r_state <= S_STREAM;
            else if (win_last) r_state <= S_FLUSH;
          end
        end
        S_STREAM: begin
          if (w_in_fire) begin
            if (w_full) begin
              r_out_valid <= 1'b1;
              r_out_data  <= w_comb[TS-1:0];
              r_out_count <= CNT_W'(TS);
              r_out_last  <= 1'b0;
              r_carry     <= w_comb[2*TS-1:TS];
              r_res       <= CNT_W'(w_total - IDX_W'(TS));
            end else begin
              r_carry <= w_comb[TS-1:0];
              r_res   <= CNT_W'(w_total);
            end
            r_base <= r_base + BASE_W'(TS);
            if (w_last_blk) r_state <= r_last ? S_FLUSH : S_IDLE;
          end
        end
        S_FLUSH: begin
          // Carry slots at or above r_res are always zero, so load as-is.
          if (w_out_free) begin
            r_out_valid <= 1'b1;
            r_out_data  <= r_carry;
            r_out_count <= r_res;
            r_out_last  <= 1'b1;
            r_carry     <= '0;
            r_res       <= '0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sparse_mac_operand_streamer.sv
// Self-checking bench for sparse_mac_operand_streamer: directed windows plus
// randomized windows, checked against a queue-based reference of the
// window/lane/mutual selection and dense repacking rules.
module tb_sparse_mac_operand_streamer;

  localparam int unsigned TS = 2;
  localparam int unsigned CB = 16;
  localparam int unsigned CW = 8;
  localparam int unsigned CNT_W = $clog2(TS + 1);

  typedef struct {
    logic [TS*CB-1:0] d;
    int               cnt;
    bit               l;
  } beat_t;

  logic              clock = 1'b0;
  logic              resetn;
  logic              win_valid, win_ready, win_last;
  logic [CW-1:0]     win_bitmask, win_mutual;
  logic              in_valid, in_ready;
  logic [TS*CB-1:0]  in_data;
  logic              out_valid, out_ready, out_last;
  logic [TS*CB-1:0]  out_data;
  logic [CNT_W-1:0]  out_count;

  sparse_mac_operand_streamer #(
    .TRANSFER_SIZE(TS), .CLUSTER_BITWIDTH(CB), .COMPRESSION_WINDOW_SIZE(CW)
  ) dut (
    .clock(clock), .resetn(resetn),
    .win_valid(win_valid), .win_ready(win_ready),
    .win_bitmask(win_bitmask), .win_mutual(win_mutual), .win_last(win_last),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_count(out_count), .out_last(out_last)
  );

  always #5 clock = ~clock;

  int               checks = 0;
  int               errors = 0;
  beat_t            exp_q[$];
  logic [CB-1:0]    pend[$];
  bit               f_win, f_in;
  bit               use_seq;
  int               ncl;
  int               stall_left;
  bit               prev_stall;
  logic [TS*CB-1:0] prev_data;
  logic [CNT_W-1:0] prev_count;
  logic             prev_last;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [CB-1:0] gen();
    if (use_seq) begin
      ncl++;
      return CB'(32'h1000 + ncl - 1);
    end
    return CB'($urandom);
  endfunction

  function automatic bit get_rdy(input int mode);
    if (mode == 1) return ($urandom_range(0, 3) != 0);
    if (mode == 2 && out_valid && stall_left > 0) begin
      stall_left--;
      return 1'b0;
    end
    return 1'b1;
  endfunction

  // One clock: called at a falling edge with inputs already set; checks the
  // outputs, records which handshakes fire on the coming rising edge.
  task automatic tick(input bit rdy);
    beat_t b;
    out_ready = rdy;
    #1;
    if (prev_stall) begin
      chk("hold_valid", 64'(out_valid), 64'(1));
      chk("hold_data", 64'(out_data), 64'(prev_data));
      chk("hold_count", 64'(out_count), 64'(prev_count));
      chk("hold_last", 64'(out_last), 64'(prev_last));
    end
    if (out_valid && !out_ready) chk("stall_in_ready", 64'(in_ready), 64'(0));
    if (out_valid && out_ready) begin
      chk("beat_expected", 64'(exp_q.size() != 0), 64'(1));
      if (exp_q.size() != 0) begin
        b = exp_q.pop_front();
        chk("beat_data", 64'(out_data), 64'(b.d));
        chk("beat_count", 64'(out_count), 64'(b.cnt));
        chk("beat_last", 64'(out_last), 64'(b.l));
      end
    end
    prev_stall = out_valid && !out_ready;
    prev_data  = out_data;
    prev_count = out_count;
    prev_last  = out_last;
    f_win = win_valid && win_ready;
    f_in  = in_valid && in_ready;
    @(negedge clock);
  endtask

  // Offer one window and all of its blocks; the model records expected beats.
  task automatic run_window(input logic [CW-1:0] m, input logic [CW-1:0] mu,
                            input bit l, input int mode);
    int               pos[$];
    logic [TS*CB-1:0] blk[$];
    logic [TS*CB-1:0] w;
    logic [CB-1:0]    cl;
    beat_t            bt;
    int               nblk, k, sent;
    bit               accepted;
    for (int p = 0; p < CW; p++) if (m[p]) pos.push_back(p);
    nblk = (pos.size() + int'(TS) - 1) / int'(TS);
    for (int b = 0; b < nblk; b++) begin
      w = '0;
      for (int j = 0; j < TS; j++) begin
        cl = gen();
        w[j*CB +: CB] = cl;
        k = b * int'(TS) + j;
        if (k < pos.size() && mu[pos[k]]) pend.push_back(cl);
      end
      blk.push_back(w);
    end
    while (pend.size() >= TS) begin
      bt.d = '0;
      for (int j = 0; j < TS; j++) bt.d[j*CB +: CB] = pend.pop_front();
      bt.cnt = TS;
      bt.l = 1'b0;
      exp_q.push_back(bt);
    end
    if (l) begin
      bt.d = '0;
      bt.cnt = pend.size();
      for (int j = 0; j < bt.cnt; j++) bt.d[j*CB +: CB] = pend.pop_front();
      bt.l = 1'b1;
      exp_q.push_back(bt);
    end
    win_bitmask = m; win_mutual = mu; win_last = l; win_valid = 1'b1;
    accepted = 1'b0;
    sent = 0;
    for (int cyc = 0; cyc < 300 && !(accepted && sent == nblk); cyc++) begin
      in_valid = accepted && (sent < nblk);
      in_data  = in_valid ? blk[sent] : '0;
      tick(get_rdy(mode));
      if (f_win) begin
        accepted = 1'b1;
        win_valid = 1'b0;
      end
      if (f_in) sent++;
    end
    win_valid = 1'b0;
    in_valid = 1'b0;
    chk("window_done", 64'(accepted && sent == nblk), 64'(1));
  endtask

  task automatic drain();
    for (int cyc = 0; cyc < 100 && exp_q.size() != 0; cyc++) tick(1'b1);
    chk("drained", 64'(exp_q.size()), 64'(0));
    repeat (2) tick(1'b1);
  endtask

  initial begin
    resetn = 1'b0; win_valid = 1'b0; win_bitmask = '0; win_mutual = '0; win_last = 1'b0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    prev_stall = 1'b0; prev_data = '0; prev_count = '0; prev_last = 1'b0;
    use_seq = 1'b1; ncl = 0; stall_left = 0;

    // Reset values
    repeat (3) @(negedge clock);
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_out_data", 64'(out_data), 64'(0));
    chk("rst_out_count", 64'(out_count), 64'(0));
    chk("rst_out_last", 64'(out_last), 64'(0));
    chk("rst_win_ready", 64'(win_ready), 64'(0));
    chk("rst_in_ready", 64'(in_ready), 64'(0));
    resetn = 1'b1;
    #1 chk("win_ready_before_edge", 64'(win_ready), 64'(0));
    @(negedge clock);
    chk("win_ready_after_edge", 64'(win_ready), 64'(1));

    // Mixed keep pattern, last window
    ncl = 0; run_window(8'hF6, 8'h66, 1'b1, 0); drain();
    ncl = 0; run_window(8'hF6, 8'h26, 1'b1, 0); drain();
    // Residual carried across windows
    ncl = 0; run_window(8'h02, 8'h02, 1'b0, 0); run_window(8'h01, 8'h01, 1'b1, 0); drain();
    // Output back-pressure for five cycles
    ncl = 0; stall_left = 5; run_window(8'hFF, 8'hFF, 1'b1, 2); drain();
    chk("stall_applied", 64'(stall_left), 64'(0));
    // Empty windows
    run_window(8'h00, 8'h00, 1'b1, 0);
    #1 chk("empty_last_in_ready", 64'(in_ready), 64'(0));
    drain();
    run_window(8'h00, 8'hFF, 1'b0, 0);
    #1 chk("empty_win_ready", 64'(win_ready), 64'(1));
    drain();

    // Randomized windows with random back-pressure
    use_seq = 1'b0;
    for (int n = 0; n < 40; n++)
      run_window(CW'($urandom), CW'($urandom), ($urandom_range(0, 3) == 0) || (n == 39), 1);
    drain();

    // Reset while streaming with one cluster held in the residual
    use_seq = 1'b1; ncl = 0;
    win_bitmask = 8'hFF; win_mutual = 8'h01; win_last = 1'b0; win_valid = 1'b1;
    for (int cyc = 0; cyc < 20; cyc++) begin
      tick(1'b1);
      if (f_win) break;
    end
    chk("rst_test_win_fire", 64'(f_win), 64'(1));
    win_valid = 1'b0;
    in_valid = 1'b1; in_data = {16'hAAAA, 16'hBBBB};
    for (int cyc = 0; cyc < 20; cyc++) begin
      tick(1'b1);
      if (f_in) break;
    end
    chk("rst_test_blk_fire", 64'(f_in), 64'(1));
    in_valid = 1'b0;
    resetn = 1'b0;
    #1;
    chk("mid_rst_out_valid", 64'(out_valid), 64'(0));
    chk("mid_rst_out_data", 64'(out_data), 64'(0));
    chk("mid_rst_out_count", 64'(out_count), 64'(0));
    chk("mid_rst_out_last", 64'(out_last), 64'(0));
    chk("mid_rst_win_ready", 64'(win_ready), 64'(0));
    chk("mid_rst_in_ready", 64'(in_ready), 64'(0));
    pend.delete(); exp_q.delete(); prev_stall = 1'b0;
    repeat (2) @(negedge clock);
    resetn = 1'b1;
    @(negedge clock);
    run_window(8'h03, 8'h03, 1'b1, 0);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
